// File: rtl/rect_draw_arbiter.sv
// rect_draw_arbiter
//   Shares the single vga_adapter plot port between NUM_REQ rectangle-draw
//   requesters. A round-robin pick in IDLE grants one requester. LATCH
//   captures its rectangle. DRAW scans it row-major at one pixel per clock,
//   clipping pixels that fall off screen. DONE returns a one-cycle done pulse.
//
// Ports
//   clock, reset     system clock; asynchronous active-high reset
//   req              level request per requester, held until its done pulse
//   req_x/req_y      top-left corner per requester (10/9-bit slices)
//   req_w/req_h      size per requester (10/9-bit slices), 0 = empty
//   req_colour       fill colour per requester (3-bit slices)
//   grant            one-hot, high from LATCH through DONE
//   done             one-cycle pulse on the served requester's bit
//   x, y, colour     pixel to vga_adapter, meaningful only while plot=1
//   plot             vga_adapter write strobe
//   busy             high whenever not IDLE
module rect_draw_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*10-1:0]  req_x,
  input  logic [NUM_REQ*9-1:0]   req_y,
  input  logic [NUM_REQ*10-1:0]  req_w,
  input  logic [NUM_REQ*9-1:0]   req_h,
  input  logic [NUM_REQ*3-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [9:0]             x,
  output logic [8:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [9:0] SCR_W = 10'(SCREEN_W);
  localparam logic [8:0] SCR_H = 9'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr, idx, sel_idx;
  logic          sel_valid;
  int unsigned   cand;

  logic [9:0] bx, bw, cx, sx, x_q;
  logic [8:0] by, bh, cy, sy, y_q;
  logic [2:0] bcol, col_q;
  logic       in_view, last_px;

  logic [9:0] rx [NUM_REQ];
  logic [8:0] ry [NUM_REQ];
  logic [9:0] rw [NUM_REQ];
  logic [8:0] rh [NUM_REQ];
  logic [2:0] rc [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rx[g] = req_x[g*10 +: 10];
    assign ry[g] = req_y[g*9 +: 9];
    assign rw[g] = req_w[g*10 +: 10];
    assign rh[g] = req_h[g*9 +: 9];
    assign rc[g] = req_colour[g*3 +: 3];
  end

  // Round-robin pick: first set req bit after the last served index, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_valid && req[cand[IW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  assign sx      = bx + cx;
  assign sy      = by + cy;
  assign in_view = (sx < SCR_W) && (sy < SCR_H);
  assign last_px = (cx == bw - 10'd1) && (cy == bh - 9'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // All handshake outputs decode from registered state so reset clears them
  // asynchronously; x/y/colour show held copies whenever nothing is plotted.
  always_comb begin
    state_next = state;
    grant      = '0;
    done       = '0;
    plot       = 1'b0;
    busy       = (state != IDLE);
    x          = x_q;
    y          = y_q;
    colour     = col_q;
    case (state)
      IDLE: if (sel_valid) state_next = LATCH;
      LATCH: begin
        grant[idx] = 1'b1;
        state_next = (rw[idx] == '0 || rh[idx] == '0) ? DONE : DRAW;
      end
      DRAW: begin
        grant[idx] = 1'b1;
        plot       = in_view;
        if (in_view) begin
          x      = sx;
          y      = sy;
          colour = bcol;
        end
        if (last_px) state_next = DONE;
      end
      DONE: begin
        grant[idx] = 1'b1;
        done[idx]  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= IW'(NUM_REQ - 1);
      idx   <= '0;
      bx    <= '0;
      by    <= '0;
      bw    <= '0;
      bh    <= '0;
      bcol  <= '0;
      cx    <= '0;
      cy    <= '0;
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
    end else begin
      case (state)
        IDLE: if (sel_valid) idx <= sel_idx;
        LATCH: begin
          bx   <= rx[idx];
          by   <= ry[idx];
          bw   <= rw[idx];
          bh   <= rh[idx];
          bcol <= rc[idx];
          cx   <= '0;
          cy   <= '0;
        end
        DRAW: begin
          if (cx == bw - 10'd1) begin
            cx <= '0;
            cy <= cy + 9'd1;
          end else begin
            cx <= cx + 10'd1;
          end
          if (in_view) begin
            x_q   <= sx;
            y_q   <= sy;
            col_q <= bcol;
          end
        end
        DONE: ptr <= idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// tb_rect_draw_arbiter
//   Directed bench for rect_draw_arbiter with NUM_REQ=4 at 320x240.
//   Steps advance one clock and sample 1 ns after the rising edge.
module tb_rect_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [39:0] req_x = '0;
  logic [35:0] req_y = '0;
  logic [39:0] req_w = '0;
  logic [35:0] req_h = '0;
  logic [11:0] req_colour = '0;
  logic [3:0]  grant, done;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [2:0]  colour;
  logic        plot, busy;

  int checks = 0;
  int errors = 0;

  rect_draw_arbiter #(.NUM_REQ(4), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .grant(grant), .done(done), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [9:0] xx, input logic [8:0] yy,
                         input logic [9:0] ww, input logic [8:0] hh, input logic [2:0] cc);
    req_x[i*10 +: 10]     = xx;
    req_y[i*9 +: 9]       = yy;
    req_w[i*10 +: 10]     = ww;
    req_h[i*9 +: 9]       = hh;
    req_colour[i*3 +: 3]  = cc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  logic [3:0] gexp;
  logic [9:0] ex;
  logic [8:0] ey;
  logic       pexp;

  initial begin
    // Reset state
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Single 2x2 at (5,7), colour 4, requester 0
    set_req(0, 10'd5, 9'd7, 10'd2, 9'd2, 3'b100);
    req = 4'b0001;
    chk("t1_c0_busy", busy, 0);
    step();
    chk("t1_c1_grant", grant, 4'b0001);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_plot", plot, 0);
    step();
    chk("t1_p0_plot", plot, 1); chk("t1_p0_x", x, 5); chk("t1_p0_y", y, 7);
    chk("t1_p0_col", colour, 4); chk("t1_p0_grant", grant, 4'b0001);
    step();
    chk("t1_p1_plot", plot, 1); chk("t1_p1_x", x, 6); chk("t1_p1_y", y, 7);
    step();
    chk("t1_p2_plot", plot, 1); chk("t1_p2_x", x, 5); chk("t1_p2_y", y, 8);
    step();
    chk("t1_p3_plot", plot, 1); chk("t1_p3_x", x, 6); chk("t1_p3_y", y, 8);
    chk("t1_p3_done", done, 0);
    step();
    chk("t1_c6_done", done, 4'b0001);
    chk("t1_c6_grant", grant, 4'b0001);
    chk("t1_c6_plot", plot, 0);
    chk("t1_c6_xhold", x, 6);
    chk("t1_c6_yhold", y, 8);
    req = 4'b0000;
    step();
    chk("t1_c7_done", done, 0);
    chk("t1_c7_grant", grant, 0);
    chk("t1_c7_busy", busy, 0);

    // Requesters 0 and 1 held high, 1x1 each; grants alternate from 0
    do_reset();
    set_req(0, 10'd10, 9'd20, 10'd1, 9'd1, 3'd1);
    set_req(1, 10'd30, 9'd40, 10'd1, 9'd1, 3'd2);
    req = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      gexp = 4'b0001 << (n % 2);
      ex   = (n % 2 == 1) ? 10'd30 : 10'd10;
      ey   = (n % 2 == 1) ? 9'd40 : 9'd20;
      step();
      chk("t2_latch_grant", grant, gexp);
      step();
      chk("t2_draw_plot", plot, 1);
      chk("t2_draw_x", x, ex);
      chk("t2_draw_y", y, ey);
      step();
      chk("t2_done", done, gexp);
      if (n == 3) req = 4'b0000;
      step();
      chk("t2_idle_grant", grant, 0);
      chk("t2_idle_busy", busy, 0);
    end
    step();
    chk("t2_quiet_busy", busy, 0);

    // Empty rectangle on requester 2
    set_req(2, 10'd100, 9'd100, 10'd0, 9'd3, 3'd7);
    req = 4'b0100;
    step();
    chk("t3_c1_busy", busy, 1);
    chk("t3_c1_grant", grant, 4'b0100);
    chk("t3_c1_plot", plot, 0);
    step();
    chk("t3_c2_done", done, 4'b0100);
    chk("t3_c2_busy", busy, 1);
    chk("t3_c2_plot", plot, 0);
    req = 4'b0000;
    step();
    chk("t3_c3_busy", busy, 0);
    chk("t3_c3_done", done, 0);

    // Clipping 4x4 at (318,238) on requester 3; req_x/req_y change mid-draw
    set_req(3, 10'd318, 9'd238, 10'd4, 9'd4, 3'd5);
    req = 4'b1000;
    step();
    chk("t4_latch_grant", grant, 4'b1000);
    for (int j = 0; j < 16; j++) begin
      ex   = 10'd318 + 10'(j % 4);
      ey   = 9'd238 + 9'(j / 4);
      pexp = (ex < 10'd320) && (ey < 9'd240);
      step();
      chk("t4_plot", plot, pexp);
      chk("t4_grant", grant, 4'b1000);
      if (pexp) begin
        chk("t4_x", x, ex);
        chk("t4_y", y, ey);
        chk("t4_col", colour, 5);
      end
      if (j == 0) begin
        req_x[30 +: 10] = 10'd0;
        req_y[27 +: 9]  = 9'd0;
      end
    end
    step();
    chk("t4_done", done, 4'b1000);
    req = 4'b0000;
    step();
    chk("t4_idle_busy", busy, 0);

    // Reset at the 3rd pixel of a 10x10 rectangle
    set_req(1, 10'd20, 9'd30, 10'd10, 9'd10, 3'd6);
    req = 4'b0010;
    step();
    chk("t6_latch_grant", grant, 4'b0010);
    step();
    step();
    step();
    chk("t6_px3_plot", plot, 1);
    chk("t6_px3_x", x, 22);
    reset = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_plot", plot, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_x", x, 0);
    chk("t6_rst_y", y, 0);
    chk("t6_rst_colour", colour, 0);
    step();
    step();
    reset = 1'b0;
    set_req(0, 10'd1, 9'd1, 10'd1, 9'd1, 3'd7);
    set_req(3, 10'd50, 9'd60, 10'd1, 9'd1, 3'd3);
    req = 4'b1001;
    chk("t6_idle_done", done, 0);
    step();
    chk("t6_first_grant", grant, 4'b0001);
    step();
    chk("t6_r0_plot", plot, 1);
    chk("t6_r0_x", x, 1);
    chk("t6_r0_col", colour, 7);
    step();
    chk("t6_r0_done", done, 4'b0001);
    req = 4'b1000;
    step();
    chk("t6_idle_done2", done, 0);
    step();
    chk("t6_second_grant", grant, 4'b1000);
    step();
    chk("t6_r3_x", x, 50);
    chk("t6_r3_y", y, 60);
    step();
    chk("t6_r3_done", done, 4'b1000);
    req = 4'b0000;
    step();
    chk("t6_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
